banco_operandos: RTL
====================

BANCO_OPERANDOS -- requirements
Module: banco_operandos

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port data_in  input  4  hex digit from switches, sampled on trigger_1/trigger_2.
REQ-004 SHALL have port op_in  input  3  opcode from switches, sampled on trigger_op.
REQ-005 SHALL have ports trigger_1, trigger_2, trigger_op  input  1 each  single-cycle capture pulses from the calculator FSM.
REQ-006 SHALL have port reset_a_reg  input  1  synchronous clear of all bank contents.
REQ-007 SHALL have port estado  input  3  calculator phase: 0 operand A, 1 operand B, 2 opcode, 3 result, 4 idle.
REQ-008 SHALL have ports operand_a, operand_b  output  16 each  captured operands.
REQ-009 SHALL have port opcode  output  3  captured opcode.
REQ-010 SHALL have port result  output  16  computed result.
REQ-011 SHALL have ports result_valid, overflow  output  1 each  result ready; carry/borrow/high-half flag.
REQ-012 SHALL have port display_value  output  16  value for the 7-segment driver.
REQ-013 SHALL have ports count_a, count_b  output  3 each  digits captured per operand (0..4).

Function
REQ-014 SHALL, on trigger_1 with count_a<4, set operand_a <= {operand_a[11:0], data_in} and increment count_a.
REQ-015 SHALL handle trigger_2 identically for operand_b/count_b; both triggers in one cycle SHALL both be captured.
REQ-016 SHALL ignore trigger_1/trigger_2 when the corresponding count is 4 (operand and count unchanged).
REQ-017 SHALL load opcode <= op_in on trigger_op; repeated pulses overwrite.
REQ-018 SHALL decode opcode: 0 add, 1 sub (A-B), 2 AND, 3 OR, 4 XOR, 5 multiply (per REQ-027/028), 6-7 result 0, overflow 0.
REQ-019 SHALL run a result sequencer with states IDLE, CALC, DONE; IDLE->CALC on the first cycle estado==3 is seen in IDLE.
REQ-020 SHALL, for opcodes other than 5, leave CALC for DONE after exactly one cycle; result/overflow/result_valid update on that edge.
REQ-021 SHALL hold DONE, result_valid=1 and result stable until reset_a_reg or rst; estado leaving 3 SHALL NOT clear DONE.
REQ-022 SHALL set overflow to the 17th-bit carry for add, A<B for sub, 0 for logic ops.
REQ-023 SHALL drive display_value: estado 0 operand_a, 1 operand_b, 2 {13'b0,opcode}, 3 result if result_valid else 0, other 0.
REQ-024 SHALL give reset_a_reg priority over all triggers in the same cycle: operands, opcode, counts, result, flags to 0, sequencer to IDLE, including mid-CALC.

Reset
REQ-025 SHALL, on rst asserted, asynchronously clear operand_a, operand_b, opcode, result, count_a, count_b, result_valid, overflow to 0 and sequencer to IDLE.
REQ-026 SHALL leave display_value combinational, thus 0 during reset when estado is 0, 2, 3 or 4.

Configuration
REQ-027 SHALL, with CALC_MULT_EN defined, implement opcode 5 as an unsigned 16x16 shift-add multiplier in CALC: 16 iterations, result = low 16 bits, overflow = high 16 bits nonzero, result_valid asserted 16 cycles after entering CALC.
REQ-028 SHALL, without CALC_MULT_EN, treat opcode 5 as opcodes 6-7 (one-cycle CALC, result 0, overflow 0) with no multiplier logic synthesized.

Verification
REQ-029 SHALL cover: trigger_1 x4 with data_in 1,2,3,4 then a 5th with 9 -> operand_a=0x1234, count_a=4.
REQ-030 SHALL cover: A=0xFFFF, B=0x0001, opcode 0, estado->3 -> after 1 cycle result=0x0000, overflow=1, result_valid=1.
REQ-031 SHALL cover: A=0x0005, B=0x0007, opcode 1 -> result=0xFFFE, overflow=1; display_value=0xFFFE while estado=3.
REQ-032 SHALL cover: CALC_MULT_EN, A=0x0100, B=0x0300, opcode 5 -> result_valid rises 16 cycles after CALC entry, result=0x0000, overflow=1.
REQ-033 SHALL cover: trigger_1 and reset_a_reg in the same cycle, and reset_a_reg mid-multiply -> all outputs 0, sequencer IDLE, result_valid stays 0.

Source files
------------

// File: rtl/banco_operandos.sv
// ---------------------------------------------------------------------------
// banco_operandos -- operand/opcode bank and result unit for the switch calculator
//
// Captures two 16-bit operands one hex digit at a time, plus a 3-bit opcode.
// When the calculator FSM reaches the result phase, a small sequencer computes
// the result once and holds it until the bank is cleared.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   data_in[3:0]           hex digit, shifted into an operand on trigger_1/2
//   op_in[2:0]             opcode, loaded on trigger_op
//   trigger_1/2/op         single-cycle capture pulses
//   reset_a_reg            synchronous clear of the whole bank (wins over triggers)
//   estado[2:0]            calculator phase: 0 A, 1 B, 2 opcode, 3 result, 4 idle
//   operand_a/b[15:0]      captured operands
//   opcode[2:0]            captured opcode
//   result[15:0]           computed result
//   result_valid           result held and ready
//   overflow               carry (add), borrow (sub), high half nonzero (mul)
//   display_value[15:0]    phase-dependent value for the 7-segment driver
//   count_a/b[2:0]         digits captured per operand (saturate at 4)
//
// Build option
//   CALC_MULT_EN  adds opcode 5: unsigned 16x16 shift-add multiply, one partial
//                 product per cycle (16 cycles). Undefined: opcode 5 yields 0.
// ---------------------------------------------------------------------------
module banco_operandos (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data_in,
    input  logic [2:0]  op_in,
    input  logic        trigger_1,
    input  logic        trigger_2,
    input  logic        trigger_op,
    input  logic        reset_a_reg,
    input  logic [2:0]  estado,
    output logic [15:0] operand_a,
    output logic [15:0] operand_b,
    output logic [2:0]  opcode,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        overflow,
    output logic [15:0] display_value,
    output logic [2:0]  count_a,
    output logic [2:0]  count_b
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] EST_A      = 3'd0;
    localparam logic [2:0] EST_B      = 3'd1;
    localparam logic [2:0] EST_OP     = 3'd2;
    localparam logic [2:0] EST_RESULT = 3'd3;

    localparam logic [2:0] MAX_DIGITS = 3'd4;

    logic [1:0] seq;

    // ---------------- operand / opcode capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_a <= '0;
            operand_b <= '0;
            opcode    <= '0;
            count_a   <= '0;
            count_b   <= '0;
        end else if (reset_a_reg) begin
            operand_a <= '0;
            operand_b <= '0;
            opcode    <= '0;
            count_a   <= '0;
            count_b   <= '0;
        end else begin
            // Digits enter from the right; extra digits past four are dropped.
            if (trigger_1 && count_a < MAX_DIGITS) begin
                operand_a <= {operand_a[11:0], data_in};
                count_a   <= count_a + 3'd1;
            end
            if (trigger_2 && count_b < MAX_DIGITS) begin
                operand_b <= {operand_b[11:0], data_in};
                count_b   <= count_b + 3'd1;
            end
            if (trigger_op)
                opcode <= op_in;
        end
    end

    // ---------------- single-cycle ALU ----------------
    logic [16:0] sum;
    logic [15:0] alu_res;
    logic        alu_ov;

    always_comb begin
        sum     = {1'b0, operand_a} + {1'b0, operand_b};
        alu_res = '0;
        alu_ov  = 1'b0;
        case (opcode)
            3'd0: begin alu_res = sum[15:0];             alu_ov = sum[16];               end
            3'd1: begin alu_res = operand_a - operand_b; alu_ov = operand_a < operand_b; end
            3'd2: alu_res = operand_a & operand_b;
            3'd3: alu_res = operand_a | operand_b;
            3'd4: alu_res = operand_a ^ operand_b;
            default: ;  // 5 (without multiplier), 6, 7: result 0, no overflow
        endcase
    end

    // ---------------- completion select ----------------
    logic        fin;
    logic [15:0] fin_res;
    logic        fin_ov;

`ifdef CALC_MULT_EN
    // Shift-add multiplier: on iteration i add A<<i when B[i] is set.
    // The accumulator is zeroed while idle so CALC always starts clean.
    logic [31:0] mul_acc;
    logic [31:0] mul_acc_nxt;
    logic [3:0]  mul_cnt;

    always_comb begin
        mul_acc_nxt = mul_acc + (operand_b[mul_cnt] ? ({16'b0, operand_a} << mul_cnt) : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc <= '0;
            mul_cnt <= '0;
        end else if (reset_a_reg || seq == S_IDLE) begin
            mul_acc <= '0;
            mul_cnt <= '0;
        end else if (seq == S_CALC) begin
            mul_acc <= mul_acc_nxt;
            mul_cnt <= mul_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        fin     = 1'b1;
        fin_res = alu_res;
        fin_ov  = alu_ov;
`ifdef CALC_MULT_EN
        if (opcode == 3'd5) begin
            fin     = (mul_cnt == 4'd15);
            fin_res = mul_acc_nxt[15:0];
            fin_ov  = |mul_acc_nxt[31:16];
        end
`endif
    end

    // ---------------- result sequencer ----------------
    // DONE is sticky: leaving the result phase does not clear it, only a
    // bank clear or reset does, so the result is computed exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq          <= S_IDLE;
            result       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else if (reset_a_reg) begin
            seq          <= S_IDLE;
            result       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (seq)
                S_IDLE: if (estado == EST_RESULT) seq <= S_CALC;
                S_CALC: if (fin) begin
                    seq          <= S_DONE;
                    result       <= fin_res;
                    overflow     <= fin_ov;
                    result_valid <= 1'b1;
                end
                S_DONE: ;
                default: seq <= S_IDLE;
            endcase
        end
    end

    // ---------------- display mux ----------------
    always_comb begin
        case (estado)
            EST_A:      display_value = operand_a;
            EST_B:      display_value = operand_b;
            EST_OP:     display_value = {13'b0, opcode};
            EST_RESULT: display_value = result_valid ? result : 16'h0000;
            default:    display_value = 16'h0000;
        endcase
    end

endmodule
